ecc_55_enc_fault_detc_wr: RTL and testbench
===========================================

Name: ecc_55_enc_fault_detc_wr

Overview:
Write-side counterpart of the 55-bit SECDED fault-detecting decoder. It sits on the FIFO write path and generates the 7-bit parity for each 55-bit data beat. Parity is produced by two lockstep encoder instances whose outputs are compared. The beat is registered into a one-entry valid/ready output stage and carries a per-beat fault flag. The block also contains an error-injection FSM that corrupts selected beats after encoding, so the downstream decoder can be exercised.

Parameters:
DATA_WIDTH, 55, data beat width; only 55 is supported.
PARITY_WIDTH, 7, SECDED parity width (6 Hamming bits plus overall parity).
CNT_WIDTH, 8, width of the saturating fault counter.

Ports:
clk  input  1  block clock
rst_n  input  1  asynchronous active-low reset
ecc_fault_detc_en  input  1  enables the lockstep compare
bypass  input  1  forces parity to zero; compare result is ignored
in_valid  input  1  input beat valid
in_ready  output  1  input beat accepted when in_valid & in_ready
data_in  input  55  raw data
out_valid  output  1  output beat valid
out_ready  input  1  downstream ready
data_out  output  55  registered data, possibly with injected bit flips
parity_out  output  7  registered parity from encoder 0
out_fault  output  1  lockstep mismatch flag for this beat
ecc_fault  output  1  sticky fault; set on any flagged beat
fault_clr  input  1  clears ecc_fault and fault_cnt
fault_cnt  output  CNT_WIDTH  saturating count of flagged beats
inj_sbit_req  input  1  pulse: arm a single-bit flip on the next accepted beat
inj_dbit_req  input  1  pulse: arm a double-bit flip on the next accepted beat
inj_pos  input  6  flip position, sampled at acceptance
inj_busy  output  1  high while an injection is armed

Behaviour:
- Reset: all outputs are 0.
  - in_ready = 1 immediately after reset, because it is combinational from out_valid = 0.
  - FSM resets to IDLE.
- Encoding:
  - parity = H-matrix product of data_in using the shared ECC55_H constant, the same matrix the decoder checks.
  - bit 6 = XOR of data_in and parity[5:0].
  - bypass = 1 forces parity to 7'h00 and out_fault to 0.
- Handshake:
  - in_ready = ~out_valid | out_ready.
  - On acceptance, data, parity and fault are registered and out_valid = 1 on the next cycle; latency is 1 cycle.
  - out_valid clears only when out_ready is high and no new beat is accepted.
  - With out_ready held high, throughput is 1 beat per cycle.
  - While out_valid & ~out_ready, all output registers hold stable.
- Fault detection (evaluated on the accepted beat):
  - mismatch = parity0 != parity1.
  - out_fault = mismatch & ecc_fault_detc_en & ~bypass.
  - On a flagged beat, ecc_fault sets and fault_cnt increments, saturating at all-ones.
  - fault_clr has priority over a same-cycle set: the counter goes to 0 and ecc_fault goes to 0.
  - Parity is always taken from encoder 0, flagged or not.
- Injection FSM, states IDLE, ARM_S, ARM_D:
  - IDLE -> ARM_S on inj_sbit_req; IDLE -> ARM_D on inj_dbit_req.
  - If both requests arrive in the same cycle, ARM_D wins.
  - Requests arriving outside IDLE are ignored.
  - ARM_S / ARM_D -> IDLE on the next accepted beat. inj_busy = state != IDLE.
  - p = inj_pos if inj_pos <= 54, else 0.
  - ARM_S flips data bit p. ARM_D flips bits p and (p+1) mod 55, so p = 54 flips bits 54 and 0.
  - Flips are applied after encoding, so parity reflects the clean data.
  - If a request arrives in the same cycle as an acceptance while in IDLE, it arms for the following beat only.
- Reset mid-operation: an in-flight beat is dropped, the FSM returns to IDLE and counters clear.

Decomposition:
- Shared package ecc55_pkg:
  - ECC55_H parity-matrix constant, shared with the decoder.
  - DATA_WIDTH and PARITY_WIDTH constants.
  - Injection FSM state typedef (IDLE / ARM_S / ARM_D).
- Sub-module ecc_55_enc: a purely combinational encoder with inputs data_in and bypass and output parity_out. It is instantiated twice (u0, u1) for lockstep.

Test Plan:
1. Reset, then in_valid with data_in = 55'h0 and out_ready = 1 -> next cycle out_valid = 1, parity_out = 7'h00, out_fault = 0; a decoder loopback reports sbit_err = dbit_err = 0.
2. Stream 16 random beats back-to-back with out_ready toggling 1010 -> no beat lost or duplicated; data and parity stay stable while out_ready = 0; every beat decodes cleanly.
3. Force u1 parity bit 0 inverted, ecc_fault_detc_en = 1, send 3 beats -> out_fault = 1 on each, ecc_fault = 1, fault_cnt = 3; pulse fault_clr -> fault_cnt = 0, ecc_fault = 0. Repeat with ecc_fault_detc_en = 0 -> no flags.
4. Force the mismatch and hold until fault_cnt saturates -> fault_cnt stays at 8'hFF; a same-cycle fault_clr and mismatch gives fault_cnt = 0.
5. inj_sbit_req with inj_pos = 10, then send data 55'h0 -> data_out = 55'h400 and the decoder reports sbit_err = 1. inj_dbit_req with inj_pos = 54 -> data_out bits 54 and 0 set, decoder reports dbit_err = 1. inj_pos = 60 -> bit 0 flipped.
6. inj_sbit_req and inj_dbit_req in the same cycle -> double-bit flip. Reset asserted while in ARM_D -> inj_busy = 0, out_valid = 0.

Source files
------------

// File: rtl/ecc55_pkg.sv
// Shared constants and types for the 55-bit SECDED encoder/decoder pair.
package ecc55_pkg;

    localparam int unsigned DATA_WIDTH   = 55;
    localparam int unsigned PARITY_WIDTH = 7;
    localparam int unsigned HAM_WIDTH    = 6;
    localparam int unsigned POS_WIDTH    = 6;

    typedef logic [HAM_WIDTH-1:0][DATA_WIDTH-1:0] h_matrix_t;

    // Data bit i sits at the i-th non-power-of-two codeword position starting at 3.
    function automatic h_matrix_t build_h();
        h_matrix_t   h;
        int unsigned pos;
        h   = '0;
        pos = 3;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            while ((pos & (pos - 1)) == 0) pos++;
            for (int unsigned j = 0; j < HAM_WIDTH; j++) h[j][i] = pos[j];
            pos++;
        end
        return h;
    endfunction

    localparam h_matrix_t ECC55_H = build_h();

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM_S = 2'd1,
        ARM_D = 2'd2
    } inj_state_t;

endpackage

// File: rtl/ecc_55_enc.sv
// Combinational SECDED parity generator for one 55-bit beat.
module ecc_55_enc
    import ecc55_pkg::*;
(
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    bypass,
    output logic [PARITY_WIDTH-1:0] parity_out
);

    logic [HAM_WIDTH-1:0] ham;

    always_comb begin
        ham        = '0;
        parity_out = '0;
        for (int unsigned j = 0; j < HAM_WIDTH; j++) ham[j] = ^(data_in & ECC55_H[j]);
        if (!bypass) parity_out = {(^data_in) ^ (^ham), ham};
    end

endmodule

// File: rtl/ecc_55_enc_fault_detc_wr.sv
// Write-path SECDED encoder with lockstep fault detection, one-entry output
// stage and an error-injection FSM that corrupts data after encoding.
module ecc_55_enc_fault_detc_wr
    import ecc55_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ecc_fault_detc_en,
    input  logic                    bypass,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic [PARITY_WIDTH-1:0] parity_out,
    output logic                    out_fault,
    output logic                    ecc_fault,
    input  logic                    fault_clr,
    output logic [CNT_WIDTH-1:0]    fault_cnt,
    input  logic                    inj_sbit_req,
    input  logic                    inj_dbit_req,
    input  logic [POS_WIDTH-1:0]    inj_pos,
    output logic                    inj_busy
);

    localparam logic [POS_WIDTH-1:0] LAST_POS = POS_WIDTH'(DATA_WIDTH - 1);

    logic [PARITY_WIDTH-1:0] parity0;
    logic [PARITY_WIDTH-1:0] parity1;
    logic                    accept;
    logic                    beat_fault;
    logic [POS_WIDTH-1:0]    pos_lo;
    logic [POS_WIDTH-1:0]    pos_hi;
    logic [DATA_WIDTH-1:0]   flip_mask;
    inj_state_t              state;
    inj_state_t              state_next;

    ecc_55_enc u0 (.data_in(data_in), .bypass(bypass), .parity_out(parity0));
    ecc_55_enc u1 (.data_in(data_in), .bypass(bypass), .parity_out(parity1));

    assign in_ready   = ~out_valid | out_ready;
    assign accept     = in_valid & in_ready;
    assign beat_fault = (parity0 != parity1) & ecc_fault_detc_en & ~bypass;
    assign inj_busy   = (state != IDLE);

    // Flip positions; the double flip wraps from bit 54 to bit 0.
    always_comb begin
        pos_lo    = (inj_pos <= LAST_POS) ? inj_pos : '0;
        pos_hi    = (pos_lo == LAST_POS) ? '0 : pos_lo + POS_WIDTH'(1);
        flip_mask = '0;
        case (state)
            ARM_S:   flip_mask = DATA_WIDTH'(1) << pos_lo;
            ARM_D:   flip_mask = (DATA_WIDTH'(1) << pos_lo) | (DATA_WIDTH'(1) << pos_hi);
            default: flip_mask = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Double-bit request wins a tie; requests while armed are dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (inj_dbit_req)      state_next = ARM_D;
                else if (inj_sbit_req) state_next = ARM_S;
            end
            ARM_S, ARM_D: begin
                if (accept) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            data_out   <= '0;
            parity_out <= '0;
            out_fault  <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            data_out   <= data_in ^ flip_mask;
            parity_out <= parity0;
            out_fault  <= beat_fault;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Sticky flag and saturating counter; clear beats a same-cycle fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ecc_fault <= 1'b0;
            fault_cnt <= '0;
        end else if (fault_clr) begin
            ecc_fault <= 1'b0;
            fault_cnt <= '0;
        end else if (accept && beat_fault) begin
            ecc_fault <= 1'b1;
            if (fault_cnt != '1) fault_cnt <= fault_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_ecc_55_enc_fault_detc_wr.sv
// Scoreboard bench for the write-path SECDED encoder with fault detection.
module tb_ecc_55_enc_fault_detc_wr;

    typedef struct {
        logic [54:0] data;
        logic [6:0]  parity;
        logic        fault;
        int          err;    // 0 clean, 1 single, 2 double, 3 not decoded
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ecc_fault_detc_en;
    logic        bypass;
    logic        in_valid;
    logic        in_ready;
    logic [54:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [54:0] data_out;
    logic [6:0]  parity_out;
    logic        out_fault;
    logic        ecc_fault;
    logic        fault_clr;
    logic [7:0]  fault_cnt;
    logic        inj_sbit_req;
    logic        inj_dbit_req;
    logic [5:0]  inj_pos;
    logic        inj_busy;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   toggle   = 1'b0;

    ecc_55_enc_fault_detc_wr #(.CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .ecc_fault_detc_en(ecc_fault_detc_en),
        .bypass(bypass), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .parity_out(parity_out), .out_fault(out_fault),
        .ecc_fault(ecc_fault), .fault_clr(fault_clr), .fault_cnt(fault_cnt),
        .inj_sbit_req(inj_sbit_req), .inj_dbit_req(inj_dbit_req),
        .inj_pos(inj_pos), .inj_busy(inj_busy)
    );

    always #5 clk = ~clk;

    // Codeword position of data bit i: skip 1, 2 and every power of two.
    function automatic logic [5:0] pos_code(input int i);
        int p = 2;
        int k = -1;
        while (k < i) begin
            p++;
            if ((p & (p - 1)) != 0) k++;
        end
        return p[5:0];
    endfunction

    function automatic logic [6:0] model_parity(input logic [54:0] d);
        logic [5:0] s = '0;
        for (int i = 0; i < 55; i++) if (d[i]) s ^= pos_code(i);
        return {(^d) ^ (^s), s};
    endfunction

    function automatic int decode_err(input logic [54:0] d, input logic [6:0] p);
        logic [5:0] s = p[5:0];
        logic       ov;
        for (int i = 0; i < 55; i++) if (d[i]) s ^= pos_code(i);
        ov = (^d) ^ (^p);
        if (ov) return 1;
        if (s != 6'd0) return 2;
        return 0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        if (toggle) out_ready = ~out_ready;
    endtask

    // Present one beat from a negedge; push the expectation when it is taken.
    task automatic send(input logic [54:0] d, input logic [54:0] ed,
                        input logic [6:0] ep, input logic ef, input int ee);
        exp_t e;
        bit   acc;
        bit   done = 1'b0;
        in_valid = 1'b1;
        data_in  = d;
        for (int i = 0; i < 100 && !done; i++) begin
            #1 acc = in_ready;
            @(posedge clk);
            if (acc) begin
                e.data = ed; e.parity = ep; e.fault = ef; e.err = ee;
                sb.push_back(e);
            end
            tick();
            done = acc;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL send_timeout: beat %0h not accepted in 100 cycles", d);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && sb.size() != 0; i++) tick();
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: compares every presented beat against the scoreboard head.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL extra_beat: got data %0h with empty scoreboard", data_out);
                end else begin
                    e = sb[0];
                    check("data_out", 64'(data_out), 64'(e.data));
                    check("parity_out", 64'(parity_out), 64'(e.parity));
                    check("out_fault", 64'(out_fault), 64'(e.fault));
                    if (out_ready) begin
                        if (e.err != 3)
                            check("decode", 64'(decode_err(data_out, parity_out)), 64'(e.err));
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [63:0] r;
        logic [54:0] d;
        rst_n = 1'b0; ecc_fault_detc_en = 1'b1; bypass = 1'b0;
        in_valid = 1'b0; data_in = '0; out_ready = 1'b1; fault_clr = 1'b0;
        inj_sbit_req = 1'b0; inj_dbit_req = 1'b0; inj_pos = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_parity", 64'(parity_out), 64'd0);
        check("rst_inj_busy", 64'(inj_busy), 64'd0);
        rst_n = 1'b1;
        tick();
        check("rst_fault_cnt", 64'(fault_cnt), 64'd0);
        check("rst_ecc_fault", 64'(ecc_fault), 64'd0);

        // Hand-computed parity for zero and single-bit data words.
        send(55'h0, 55'h0, 7'h00, 1'b0, 0);
        send(55'h1, 55'h1, 7'h43, 1'b0, 0);
        send(55'h2, 55'h2, 7'h45, 1'b0, 0);
        send(55'h4, 55'h4, 7'h46, 1'b0, 0);
        send(55'h8, 55'h8, 7'h07, 1'b0, 0);
        in_valid = 1'b0;
        drain();

        // Back-to-back stream with out_ready toggling every cycle.
        toggle = 1'b1;
        for (int i = 0; i < 16; i++) begin
            r = {$urandom(), $urandom()};
            d = r[54:0];
            send(d, d, model_parity(d), 1'b0, 0);
        end
        in_valid = 1'b0;
        drain();
        toggle = 1'b0;
        out_ready = 1'b1;
        tick();

        // Lockstep mismatch: encoder 1 disagrees with encoder 0.
        force dut.parity1 = 7'h55;
        repeat (3) send(55'h0, 55'h0, 7'h00, 1'b1, 0);
        in_valid = 1'b0;
        drain();
        check("fault_sticky", 64'(ecc_fault), 64'd1);
        check("fault_cnt_3", 64'(fault_cnt), 64'd3);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        check("clr_cnt", 64'(fault_cnt), 64'd0);
        check("clr_fault", 64'(ecc_fault), 64'd0);
        ecc_fault_detc_en = 1'b0;
        repeat (3) send(55'h0, 55'h0, 7'h00, 1'b0, 0);
        in_valid = 1'b0;
        drain();
        check("dis_cnt", 64'(fault_cnt), 64'd0);
        check("dis_fault", 64'(ecc_fault), 64'd0);
        ecc_fault_detc_en = 1'b1;
        bypass = 1'b1;
        send(55'h1, 55'h1, 7'h00, 1'b0, 3);
        bypass = 1'b0;
        in_valid = 1'b0;
        drain();
        check("bypass_cnt", 64'(fault_cnt), 64'd0);

        // Saturation, then clear racing a flagged beat.
        repeat (260) send(55'h0, 55'h0, 7'h00, 1'b1, 0);
        in_valid = 1'b0;
        drain();
        check("sat_cnt", 64'(fault_cnt), 64'hFF);
        fault_clr = 1'b1;
        send(55'h0, 55'h0, 7'h00, 1'b1, 0);
        fault_clr = 1'b0;
        in_valid = 1'b0;
        check("race_cnt", 64'(fault_cnt), 64'd0);
        check("race_fault", 64'(ecc_fault), 64'd0);
        drain();
        release dut.parity1;

        // Error injection.
        inj_sbit_req = 1'b1; inj_pos = 6'd10;
        tick();
        inj_sbit_req = 1'b0;
        check("arm_s_busy", 64'(inj_busy), 64'd1);
        send(55'h0, 55'h400, 7'h00, 1'b0, 1);
        in_valid = 1'b0;
        check("s_done_busy", 64'(inj_busy), 64'd0);
        inj_dbit_req = 1'b1; inj_pos = 6'd54;
        tick();
        inj_dbit_req = 1'b0;
        send(55'h0, 55'h40000000000001, 7'h00, 1'b0, 2);
        in_valid = 1'b0;
        inj_sbit_req = 1'b1; inj_pos = 6'd60;
        tick();
        inj_sbit_req = 1'b0;
        send(55'h0, 55'h1, 7'h00, 1'b0, 1);
        inj_sbit_req = 1'b1; inj_pos = 6'd0;
        in_valid = 1'b0;
        tick();
        inj_sbit_req = 1'b0;
        send(55'h1, 55'h0, 7'h43, 1'b0, 1);
        in_valid = 1'b0;
        inj_sbit_req = 1'b1; inj_dbit_req = 1'b1; inj_pos = 6'd5;
        tick();
        inj_sbit_req = 1'b0; inj_dbit_req = 1'b0;
        send(55'h0, 55'h60, 7'h00, 1'b0, 2);
        in_valid = 1'b0;
        inj_sbit_req = 1'b1; inj_pos = 6'd20;
        tick();
        inj_sbit_req = 1'b0; inj_dbit_req = 1'b1;
        tick();
        inj_dbit_req = 1'b0;
        send(55'h0, 55'h100000, 7'h00, 1'b0, 1);
        in_valid = 1'b0;
        drain();

        // Request together with an acceptance arms only the following beat.
        inj_sbit_req = 1'b1; inj_pos = 6'd3;
        send(55'h8, 55'h8, 7'h07, 1'b0, 0);
        inj_sbit_req = 1'b0;
        check("late_arm_busy", 64'(inj_busy), 64'd1);
        send(55'h8, 55'h0, 7'h07, 1'b0, 1);
        in_valid = 1'b0;
        drain();

        // Reset while a beat is stalled and a double flip is armed.
        out_ready = 1'b0;
        send(55'h0, 55'h0, 7'h00, 1'b0, 0);
        in_valid = 1'b0;
        inj_dbit_req = 1'b1; inj_pos = 6'd7;
        tick();
        inj_dbit_req = 1'b0;
        check("pre_rst_busy", 64'(inj_busy), 64'd1);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(inj_busy), 64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd1);
        sb.delete();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(55'h8, 55'h8, 7'h07, 1'b0, 0);
        in_valid = 1'b0;
        drain();
        check("post_rst_cnt", 64'(fault_cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
